// File: rtl/vx_cache_flush_ctrl_pkg.sv
// Shared sizing helpers for the per-bank cache maintenance sequencer.
package vx_cache_flush_ctrl_pkg;

   // Width helper: a selector over a single entry still needs one bit of storage.
   function automatic int up(input int x);
      return (x < 1) ? 1 : x;
   endfunction

   // Number of cache lines held by one bank.
   function automatic int lines_per_bank(input int cache_size, input int line_size,
                                         input int num_banks, input int num_ways);
      return cache_size / (line_size * num_banks * num_ways);
   endfunction

endpackage

// File: rtl/vx_cache_flush_ctrl.sv
// Per-bank maintenance sequencer. After reset it walks every line to initialise
// the tag and replacement stores. On a flush request it walks every line (and
// every way in writeback mode), issuing one flush op per entry. It then waits
// for the bank pipeline to drain and returns the request tag as a completion.
// busy is high in every state except IDLE so the bank can hold off core traffic.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high. A valid output, once raised, holds its payload stable until that
// transfer. Every valid/ready output here is a decode of registered state gated
// by reset, so none depends on a same-cycle input.
module vx_cache_flush_ctrl
   import vx_cache_flush_ctrl_pkg::*;
#(
   parameter int CACHE_SIZE = 1024,
   parameter int LINE_SIZE  = 64,
   parameter int NUM_BANKS  = 1,
   parameter int NUM_WAYS   = 1,
   parameter int WRITEBACK  = 0,
   parameter int TAG_WIDTH  = 1,
   localparam int LINES     = lines_per_bank(CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS),
   localparam int LW        = up($clog2(LINES)),
   localparam int WW        = up($clog2(NUM_WAYS))
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush_req_valid,
   input  logic [TAG_WIDTH-1:0] flush_req_tag,
   output logic                 flush_req_ready,
   output logic                 flush_rsp_valid,
   output logic [TAG_WIDTH-1:0] flush_rsp_tag,
   input  logic                 flush_rsp_ready,
   output logic                 init_valid,
   output logic [LW-1:0]        init_line,
   output logic                 flush_valid,
   output logic [LW-1:0]        flush_line,
   output logic [WW-1:0]        flush_way,
   input  logic                 flush_ready,
   input  logic                 pipe_empty,
   output logic                 busy
);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_FLUSH,
      S_DRAIN,
      S_DONE
   } state_e;

   localparam logic [LW-1:0] LAST_LINE = LW'(LINES - 1);
   localparam logic [WW-1:0] LAST_WAY  = WW'(NUM_WAYS - 1);

   state_e               state_q, state_d;
   logic [LW-1:0]        line_q, line_d;
   logic [WW-1:0]        way_q, way_d;
   logic [TAG_WIDTH-1:0] tag_q, tag_d;
   logic                 last_way;
   logic                 active;

   // State, walk counters and captured tag; reset restarts the init walk.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_INIT;
         line_q  <= '0;
         way_q   <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
         way_q   <= way_d;
         tag_q   <= tag_d;
      end
   end

   // Next-state logic and the line/way walk.
   always_comb begin
      state_d = state_q;
      line_d  = line_q;
      way_d   = way_q;
      tag_d   = tag_q;
      // Without writeback only the line advances, so every op ends its line.
      if (WRITEBACK != 0) begin
         last_way = (way_q == LAST_WAY);
      end else begin
         last_way = 1'b1;
      end
      case (state_q)
         S_INIT: begin
            if (line_q == LAST_LINE) begin
               line_d  = '0;
               state_d = S_IDLE;
            end else begin
               line_d = line_q + LW'(1);
            end
         end
         S_IDLE: begin
            if (flush_req_valid) begin
               tag_d   = flush_req_tag;
               line_d  = '0;
               way_d   = '0;
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (flush_ready) begin
               if (last_way) begin
                  way_d = '0;
                  if (line_q == LAST_LINE) begin
                     line_d  = '0;
                     state_d = S_DRAIN;
                  end else begin
                     line_d = line_q + LW'(1);
                  end
               end else begin
                  way_d = way_q + WW'(1);
               end
            end
         end
         S_DRAIN: begin
            if (pipe_empty) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (flush_rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_INIT;
            line_d  = '0;
            way_d   = '0;
         end
      endcase
   end

   // Output decode from registered state, forced quiet while reset is high.
   always_comb begin
      active          = ~reset;
      init_valid      = active && (state_q == S_INIT);
      flush_req_ready = active && (state_q == S_IDLE);
      flush_valid     = active && (state_q == S_FLUSH);
      flush_rsp_valid = active && (state_q == S_DONE);
      busy            = reset || (state_q != S_IDLE);
      init_line       = active ? line_q : '0;
      flush_line      = active ? line_q : '0;
      flush_rsp_tag   = active ? tag_q : '0;
      if ((WRITEBACK != 0) && active) begin
         flush_way = way_q;
      end else begin
         flush_way = '0;
      end
   end

endmodule
